// File: rtl/y_writer.sv
// y_writer: drains MAC row results, converts FloPoCo to IEEE-754
// double and writes them to consecutive 8-byte addresses.
module y_writer #(
  parameter int FIFO_DEPTH  = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  y_base,
  input  logic [COUNT_WIDTH-1:0] row_count,
  input  logic                   push_to_y,
  input  logic [65:0]            v_to_y,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [63:0]            mem_data,
  input  logic                   mem_stall,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   unexpected
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [COUNT_WIDTH-1:0] rows_q, rows_d;
  logic [COUNT_WIDTH-1:0] iss_q, iss_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW:0]            cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [63:0]            data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   unx_q, unx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [63:0]            fifo_q [FIFO_DEPTH];

  logic [63:0] conv;
  logic [PW:0] occ;
  logic        accept;
  logic        load;
  logic        take;
  logic        fifo_we;

  // Exception code picks zero, normal, infinity or quiet-NaN encoding
  always_comb begin
    conv = 64'h7FF8_0000_0000_0000;
    unique case (v_to_y[65:64])
      2'b00:   conv = {v_to_y[63], 63'b0};
      2'b01:   conv = v_to_y[63:0];
      2'b10:   conv = {v_to_y[63], 11'h7FF, 52'b0};
      default: conv = 64'h7FF8_0000_0000_0000;
    endcase
  end

  // Buffer, output register, counters and state sequencing
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rows_d  = rows_q;
    iss_d   = iss_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unx_d   = unx_q;

    // The output register counts as the head slot of the buffer
    accept  = req_q && !mem_stall;
    load    = (cnt_q != '0) && (!req_q || !mem_stall);
    occ     = cnt_q + (PW+1)'(req_q);
    take    = (state_q == RUN) && push_to_y && (acc_q != rows_q);
    fifo_we = take && ((occ != FULL_C) || accept);

    if (load) begin
      rd_d   = rd_q + PW'(1);
      req_d  = 1'b1;
      addr_d = base_q + (ADDR_WIDTH'(iss_q) << 3);
      data_d = fifo_q[rd_q];
      iss_d  = iss_q + COUNT_WIDTH'(1);
    end else if (accept) begin
      req_d = 1'b0;
    end

    if (take) acc_d = acc_q + COUNT_WIDTH'(1);
    if (fifo_we) wr_d = wr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(fifo_we) - (PW+1)'(load);

    if (take && !fifo_we) ovf_d = 1'b1;
    if (push_to_y && !take) unx_d = 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d  = y_base;
          rows_d  = row_count;
          iss_d   = '0;
          acc_d   = '0;
          wr_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
          req_d   = 1'b0;
          ovf_d   = 1'b0;
          unx_d   = 1'b0;
          state_d = (row_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((iss_d == rows_q) && !req_d) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Result storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_q[wr_q] <= conv;
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      iss_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unx_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      iss_q   <= iss_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      unx_q   <= unx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign unexpected = unx_q;

endmodule

// File: tb/tb_y_writer.sv
// tb_y_writer: directed scenarios for y_writer with
// hand-computed write addresses, data and flag timing.
module tb_y_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] y_base;
  logic [31:0] row_count;
  logic        push_to_y;
  logic [65:0] v_to_y;
  logic        mem_req;
  logic [47:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_stall;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        unexpected;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [47:0] wa[$];
  logic [63:0] wd[$];
  int          wc[$];

  y_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y_base     (y_base),
    .row_count  (row_count),
    .push_to_y  (push_to_y),
    .v_to_y     (v_to_y),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_stall  (mem_stall),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .unexpected (unexpected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && mem_req && !mem_stall) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    push_to_y = 1'b0;
    v_to_y = '0;
    mem_stall = 1'b0;
    y_base = '0;
    row_count = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic start_run(input logic [47:0] b, input logic [31:0] n);
    start = 1'b1;
    y_base = b;
    row_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push_one(input logic [65:0] v);
    push_to_y = 1'b1;
    v_to_y = v;
    tick();
    push_to_y = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    push_to_y = 1'b0;
    v_to_y = '0;
    mem_stall = 1'b0;
    y_base = '0;
    row_count = '0;
    tick();
    tick();
    n_chk++;
    if ({mem_req, busy, done, overflow, unexpected} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {mem_req, busy, done, overflow, unexpected});
    end
    n_chk++;
    if (mem_addr !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    n_chk++;
    if (mem_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", mem_data);
    end
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({mem_req, busy, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 000", {mem_req, busy, done});
    end
  endtask

  task automatic test_basic();
    int t0;
    int dc;
    do_reset();
    start_run(48'h1000, 32'd3);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    t0 = cyc;
    push_one({2'b01, 1'b0, 11'h3FF, 52'h0});
    push_one({2'b00, 1'b1, 11'h123, 52'h5});
    push_one({2'b11, 1'b1, 11'h001, 52'h1});
    wait_done(20, dc);
    n_chk++;
    if (wa.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", wa.size());
    end else begin
      n_chk++;
      if (wc[0] !== t0 + 2) begin
        n_fail++;
        $display("FAIL basic_latency: got %0d want %0d", wc[0], t0 + 2);
      end
      n_chk++;
      if (wc[2] !== t0 + 4) begin
        n_fail++;
        $display("FAIL basic_thruput: got %0d want %0d", wc[2], t0 + 4);
      end
      n_chk++;
      if (wa[0] !== 48'h1000 || wd[0] !== 64'h3FF0_0000_0000_0000) begin
        n_fail++;
        $display("FAIL basic_w0: got %h/%h want 1000/3ff0000000000000",
                 wa[0], wd[0]);
      end
      n_chk++;
      if (wa[1] !== 48'h1008 || wd[1] !== 64'h8000_0000_0000_0000) begin
        n_fail++;
        $display("FAIL basic_w1: got %h/%h want 1008/8000000000000000",
                 wa[1], wd[1]);
      end
      n_chk++;
      if (wa[2] !== 48'h1010 || wd[2] !== 64'h7FF8_0000_0000_0000) begin
        n_fail++;
        $display("FAIL basic_w2: got %h/%h want 1010/7ff8000000000000",
                 wa[2], wd[2]);
      end
      n_chk++;
      if (dc !== wc[2] + 1) begin
        n_fail++;
        $display("FAIL basic_done: got cycle %0d want %0d", dc, wc[2] + 1);
      end
    end
    n_chk++;
    if ({overflow, unexpected, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_flags: got %b want 000",
               {overflow, unexpected, busy});
    end
  endtask

  task automatic test_stall();
    int dc;
    do_reset();
    start_run(48'h2000, 32'd3);
    push_one({2'b10, 1'b0, 11'h012, 52'h3});
    push_one({2'b01, 1'b1, 11'h400, 52'h8_0000_0000_0000});
    push_one({2'b01, 64'h0123_4567_89AB_CDEF});
    mem_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 48'h2008 ||
          mem_data !== 64'hC008_0000_0000_0000) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %b/%h/%h want 1/2008/c008000000000000",
                 k, mem_req, mem_addr, mem_data);
      end
      tick();
    end
    mem_stall = 1'b0;
    wait_done(20, dc);
    n_chk++;
    if (dc == -1) begin
      n_fail++;
      $display("FAIL stall_done: got timeout want done");
    end
    n_chk++;
    if (wa.size() != 3) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 3", wa.size());
    end else begin
      n_chk++;
      if (wa[0] !== 48'h2000 || wd[0] !== 64'h7FF0_0000_0000_0000 ||
          wa[1] !== 48'h2008 || wd[1] !== 64'hC008_0000_0000_0000 ||
          wa[2] !== 48'h2010 || wd[2] !== 64'h0123_4567_89AB_CDEF) begin
        n_fail++;
        $display("FAIL stall_order: got %h/%h %h/%h %h/%h want in-order writes",
                 wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      end
    end
  endtask

  task automatic test_overflow();
    int found;
    do_reset();
    mem_stall = 1'b1;
    start_run(48'h3000, 32'd33);
    for (int i = 0; i < 33; i++) begin
      push_one({2'b01, 64'(i + 1)});
      if (i == 31) begin
        n_chk++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: got %b want 0", overflow);
        end
      end
    end
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    mem_stall = 1'b0;
    repeat (45) tick();
    n_chk++;
    if (wa.size() != 32) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d want 32", wa.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_chk++;
        if (wa[i] !== 48'h3000 + 48'(8 * i) || wd[i] !== 64'(i + 1)) begin
          n_fail++;
          $display("FAIL ovf_w%0d: got %h/%h want %h/%h", i, wa[i], wd[i],
                   48'h3000 + 48'(8 * i), 64'(i + 1));
        end
      end
    end
    found = 0;
    foreach (wa[i]) if (wa[i] === 48'h3100) found = 1;
    n_chk++;
    if (found !== 0) begin
      n_fail++;
      $display("FAIL ovf_skipped: got address 3100 present want absent");
    end
    n_chk++;
    if (unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_unexp: got %b want 0", unexpected);
    end
  endtask

  task automatic test_row_limit();
    int dc;
    do_reset();
    start_run(48'hFFFF_FFFF_FFF8, 32'd2);
    push_one({2'b10, 1'b1, 11'h555, 52'h1});
    push_one({2'b00, 1'b0, 11'h7FF, 52'hF});
    n_chk++;
    if (unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL lim_early: got %b want 0", unexpected);
    end
    push_one({2'b01, 64'h1});
    n_chk++;
    if (unexpected !== 1'b1) begin
      n_fail++;
      $display("FAIL lim_unexp: got %b want 1", unexpected);
    end
    wait_done(20, dc);
    n_chk++;
    if (dc == -1) begin
      n_fail++;
      $display("FAIL lim_done: got timeout want done");
    end
    n_chk++;
    if (wa.size() != 2) begin
      n_fail++;
      $display("FAIL lim_count: got %0d want 2", wa.size());
    end else begin
      n_chk++;
      if (wa[0] !== 48'hFFFF_FFFF_FFF8 || wd[0] !== 64'hFFF0_0000_0000_0000) begin
        n_fail++;
        $display("FAIL lim_w0: got %h/%h want fffffffffff8/fff0000000000000",
                 wa[0], wd[0]);
      end
      n_chk++;
      if (wa[1] !== 48'h0 || wd[1] !== 64'h0) begin
        n_fail++;
        $display("FAIL lim_wrap: got %h/%h want 0/0", wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_zero_rows();
    do_reset();
    start_run(48'h7000, 32'd0);
    n_chk++;
    if ({done, busy, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_done: got %b want 100", {done, busy, mem_req});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_req%0d: got %b want 0", k, mem_req);
      end
    end
    push_one({2'b01, 64'h55});
    n_chk++;
    if ({unexpected, done} !== 2'b11) begin
      n_fail++;
      $display("FAIL zero_unexp: got %b want 11", {unexpected, done});
    end
    tick();
    tick();
    n_chk++;
    if (wa.size() != 0) begin
      n_fail++;
      $display("FAIL zero_writes: got %0d want 0", wa.size());
    end
  endtask

  task automatic test_reset_midrun();
    int dc;
    do_reset();
    mem_stall = 1'b1;
    start_run(48'h5000, 32'd8);
    for (int i = 0; i < 4; i++) push_one({2'b01, 64'(i + 100)});
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req: got %b want 1", mem_req);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({mem_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_async: got %b want 00", {mem_req, busy});
    end
    tick();
    tick();
    rst = 1'b1;
    mem_stall = 1'b0;
    tick();
    repeat (3) tick();
    n_chk++;
    if ({mem_req, busy, done, overflow, unexpected} !== 5'b0 ||
        wa.size() != 0) begin
      n_fail++;
      $display("FAIL mid_idle: got %b/%0d want 00000/0",
               {mem_req, busy, done, overflow, unexpected}, wa.size());
    end
    clear_log();
    start_run(48'h6000, 32'd1);
    push_one({2'b01, 64'hBFF0_0000_0000_0000});
    wait_done(20, dc);
    n_chk++;
    if (dc == -1 || wa.size() != 1) begin
      n_fail++;
      $display("FAIL mid_restart: got done %0d count %0d want done/1", dc, wa.size());
    end else begin
      n_chk++;
      if (wa[0] !== 48'h6000 || wd[0] !== 64'hBFF0_0000_0000_0000) begin
        n_fail++;
        $display("FAIL mid_w0: got %h/%h want 6000/bff0000000000000",
                 wa[0], wd[0]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_row_limit();
    test_zero_rows();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
